// File: rtl/matrix_addr_gen_pkg.sv
// Shared types and constants for the matrix address generator.
//   state_e : job FSM states (IDLE / RUN / DONE)
//   order_e : traversal order; ROW_INNER keeps the legacy row-fastest walk
//   elem_shift : log2 of the default element size
package matrix_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    ORDER_ROW_INNER = 1'b0,
    ORDER_COL_INNER = 1'b1
  } order_e;

  localparam int unsigned ELEM_BYTES_DEFAULT = 4;
  localparam int unsigned elem_shift         = $clog2(ELEM_BYTES_DEFAULT);

endpackage

// File: rtl/matrix_addr_gen_if.sv
// Tuple stream from the address generator to the DRAM request generators.
//   idx_valid/idx_ready : beat handshake (producer -> consumer / back)
//   row_idx, col_idx    : element coordinates
//   addr                : byte address of the element
//   idx_last            : final element of the job
interface matrix_addr_gen_if #(
  parameter int unsigned row_width  = 5,
  parameter int unsigned col_width  = 5,
  parameter int unsigned addr_width = 64
);
  logic                  idx_valid;
  logic                  idx_ready;
  logic [row_width-1:0]  row_idx;
  logic [col_width-1:0]  col_idx;
  logic [addr_width-1:0] addr;
  logic                  idx_last;

  modport master (
    output idx_valid, row_idx, col_idx, addr, idx_last,
    input  idx_ready
  );

  modport slave (
    input  idx_valid, row_idx, col_idx, addr, idx_last,
    output idx_ready
  );
endinterface

// File: rtl/matrix_addr_gen_axis_counter.sv
// One matrix axis counter with a runtime limit.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : force count to zero (job start)
//   inc_i      : advance by one, wrapping to zero after limit_i-1
//   limit_i    : number of positions on this axis (1..2**width while running)
//   count_o    : current position
//   wrap_o     : count_o is the last position, so the next inc wraps
module axis_counter #(
  parameter int unsigned width = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [width:0]   limit_i,
  output logic [width-1:0] count_o,
  output logic             wrap_o
);
  logic [width-1:0] count_q, count_d;

  assign wrap_o  = ({1'b0, count_q} == (limit_i - (width+1)'(1)));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/matrix_addr_gen.sv
// Walks a runtime-sized rows x cols matrix and emits one (row, col, addr)
// tuple per beat.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, abort      : job start pulse (IDLE only) / job cancel
//   cfg_rows/cfg_cols : matrix dimensions, 0 gives an empty job
//   cfg_base          : byte address of element (0,0)
//   cfg_row_stride    : byte distance between rows
//   cfg_inner_col     : 0 row fastest, 1 column fastest
//   idx               : tuple stream (master side)
//   busy, done        : FSM not idle / one-cycle completion pulse
module matrix_addr_gen
  import matrix_addr_gen_pkg::*;
#(
  parameter int unsigned row_width  = 5,
  parameter int unsigned col_width  = 5,
  parameter int unsigned addr_width = 64,
  parameter int unsigned elem_bytes = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [row_width:0]    cfg_rows,
  input  logic [col_width:0]    cfg_cols,
  input  logic [addr_width-1:0] cfg_base,
  input  logic [addr_width-1:0] cfg_row_stride,
  input  logic                  cfg_inner_col,
  matrix_addr_gen_if.master     idx,
  output logic                  busy,
  output logic                  done
);
  localparam logic [addr_width-1:0] ColStep =
    addr_width'(1) << $clog2(elem_bytes);

  state_e                state_q, state_d;
  order_e                order_q;
  logic [row_width:0]    rows_q;
  logic [col_width:0]    cols_q;
  logic [addr_width-1:0] stride_q;
  logic [addr_width-1:0] addr_q;
  logic [addr_width-1:0] row_base_q;
  logic [addr_width-1:0] col_base_q;

  logic                  start_job, beat, last;
  logic                  row_inc, col_inc, row_wrap, col_wrap;
  logic [row_width-1:0]  row_cnt;
  logic [col_width-1:0]  col_cnt;

  assign start_job = (state_q == ST_IDLE) && start;
  // abort wins over a same-cycle handshake: the beat is not consumed
  assign beat      = (state_q == ST_RUN) && idx.idx_ready && !abort;
  assign last      = row_wrap && col_wrap;
  // inner axis steps every beat, outer axis only when the inner one wraps
  assign row_inc   = beat && ((order_q == ORDER_ROW_INNER) || col_wrap);
  assign col_inc   = beat && ((order_q == ORDER_COL_INNER) || row_wrap);

  axis_counter #(.width(row_width)) u_row_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (start_job),
    .inc_i   (row_inc),
    .limit_i (rows_q),
    .count_o (row_cnt),
    .wrap_o  (row_wrap)
  );

  axis_counter #(.width(col_width)) u_col_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (start_job),
    .inc_i   (col_inc),
    .limit_i (cols_q),
    .count_o (col_cnt),
    .wrap_o  (col_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ((cfg_rows == '0) || (cfg_cols == '0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat && last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Incremental address: the inner axis adds its step to addr_q; on an
  // inner wrap the outer-axis base register advances and reseeds addr_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      order_q    <= ORDER_ROW_INNER;
      rows_q     <= '0;
      cols_q     <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
    end else if (start_job) begin
      order_q    <= order_e'(cfg_inner_col);
      rows_q     <= cfg_rows;
      cols_q     <= cfg_cols;
      stride_q   <= cfg_row_stride;
      addr_q     <= cfg_base;
      row_base_q <= cfg_base;
      col_base_q <= cfg_base;
    end else if (beat) begin
      if (order_q == ORDER_ROW_INNER) begin
        if (row_wrap) begin
          col_base_q <= col_base_q + ColStep;
          addr_q     <= col_base_q + ColStep;
        end else begin
          addr_q     <= addr_q + stride_q;
        end
      end else begin
        if (col_wrap) begin
          row_base_q <= row_base_q + stride_q;
          addr_q     <= row_base_q + stride_q;
        end else begin
          addr_q     <= addr_q + ColStep;
        end
      end
    end
  end

  assign idx.idx_valid = (state_q == ST_RUN);
  assign idx.idx_last  = (state_q == ST_RUN) && last;
  assign idx.row_idx   = row_cnt;
  assign idx.col_idx   = col_cnt;
  assign idx.addr      = addr_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE) && !abort;
endmodule

// File: tb/tb_matrix_addr_gen.sv
module tb_matrix_addr_gen;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = 64;
  localparam int unsigned EB = 4;

  typedef struct {
    int unsigned   r;
    int unsigned   c;
    logic [AW-1:0] a;
  } tup_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW:0]   cfg_rows = '0;
  logic [CW:0]   cfg_cols = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_row_stride = '0;
  logic          cfg_inner_col = 1'b0;
  logic          busy, done;

  int n_cmp = 0;
  int n_err = 0;
  tup_t exp_q[$];

  matrix_addr_gen_if #(.row_width(RW), .col_width(CW), .addr_width(AW)) u_if ();

  matrix_addr_gen #(
    .row_width(RW), .col_width(CW), .addr_width(AW), .elem_bytes(EB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_rows       (cfg_rows),
    .cfg_cols       (cfg_cols),
    .cfg_base       (cfg_base),
    .cfg_row_stride (cfg_row_stride),
    .cfg_inner_col  (cfg_inner_col),
    .idx            (u_if.master),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: enumerate the matrix in traversal order with plain arithmetic.
  task automatic build_expected(input int unsigned rows, input int unsigned cols,
                                input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                input bit inner_col);
    tup_t t;
    exp_q.delete();
    if (inner_col) begin
      for (int unsigned r = 0; r < rows; r++)
        for (int unsigned c = 0; c < cols; c++) begin
          t.r = r; t.c = c;
          t.a = base + AW'(r) * stride + AW'(c * EB);
          exp_q.push_back(t);
        end
    end else begin
      for (int unsigned c = 0; c < cols; c++)
        for (int unsigned r = 0; r < rows; r++) begin
          t.r = r; t.c = c;
          t.a = base + AW'(r) * stride + AW'(c * EB);
          exp_q.push_back(t);
        end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({u_if.idx_valid, u_if.idx_last, busy, done, u_if.row_idx, u_if.col_idx, u_if.addr}
        !== '0) begin
      n_err++;
      $display("FAIL %s: got valid=%b last=%b busy=%b done=%b r=%0d c=%0d a=%h, expected all zero",
               name, u_if.idx_valid, u_if.idx_last, busy, done,
               u_if.row_idx, u_if.col_idx, u_if.addr);
    end
  endtask

  // ready_mode: 0 always ready, 1 random, 2 repeating 1,0,0,1
  task automatic run_job(input string name, input int unsigned rows, input int unsigned cols,
                         input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input bit inner_col, input int ready_mode, input bit abort_with_start);
    int unsigned n, got, cyc, budget;
    bit held, rdy;
    logic [RW-1:0] p_r;
    logic [CW-1:0] p_c;
    logic [AW-1:0] p_a;
    logic p_l;
    tup_t e;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    build_expected(rows, cols, base, stride, inner_col);
    n = rows * cols;
    cfg_rows = (RW+1)'(rows);
    cfg_cols = (CW+1)'(cols);
    cfg_base = base;
    cfg_row_stride = stride;
    cfg_inner_col = inner_col;
    start = 1'b1;
    abort = abort_with_start;
    step();
    start = 1'b0;
    abort = 1'b0;
    // configuration must be ignored once the job is running
    cfg_rows = (RW+1)'($urandom);
    cfg_cols = (CW+1)'($urandom);
    cfg_base = {$urandom, $urandom};
    cfg_row_stride = {$urandom, $urandom};
    cfg_inner_col = 1'($urandom);

    if (n == 0) begin
      n_cmp++;
      if ({u_if.idx_valid, done, busy} !== 3'b011) begin
        n_err++;
        $display("FAIL %s empty_done: got valid=%b done=%b busy=%b, expected 0 1 1",
                 name, u_if.idx_valid, done, busy);
      end
      step();
      n_cmp++;
      if ({u_if.idx_valid, done, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL %s empty_idle: got valid=%b done=%b busy=%b, expected 0 0 0",
                 name, u_if.idx_valid, done, busy);
      end
      return;
    end

    n_cmp++;
    if (u_if.idx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s first_valid: got %b, expected 1", name, u_if.idx_valid);
    end

    got = 0; cyc = 0; held = 0;
    budget = n * 8 + 20;
    while (got < n && cyc < budget) begin
      if (held) begin
        n_cmp++;
        if ({u_if.row_idx, u_if.col_idx, u_if.addr, u_if.idx_last} !== {p_r, p_c, p_a, p_l}) begin
          n_err++;
          $display("FAIL %s stall_hold: got r=%0d c=%0d a=%h last=%b, expected r=%0d c=%0d a=%h last=%b",
                   name, u_if.row_idx, u_if.col_idx, u_if.addr, u_if.idx_last, p_r, p_c, p_a, p_l);
        end
      end
      n_cmp++;
      if (u_if.idx_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL %s run_flags: got valid=%b busy=%b done=%b, expected 1 1 0",
                 name, u_if.idx_valid, busy, done);
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = pat[cyc % 4];
      endcase
      u_if.idx_ready = rdy;
      if (u_if.idx_valid === 1'b1 && rdy) begin
        e = exp_q[got];
        n_cmp++;
        if ({u_if.row_idx, u_if.col_idx, u_if.addr, u_if.idx_last} !==
            {RW'(e.r), CW'(e.c), e.a, (got == n - 1)}) begin
          n_err++;
          $display("FAIL %s beat %0d: got r=%0d c=%0d a=%h last=%b, expected r=%0d c=%0d a=%h last=%b",
                   name, got, u_if.row_idx, u_if.col_idx, u_if.addr, u_if.idx_last,
                   e.r, e.c, e.a, (got == n - 1));
        end
        got++;
        held = 0;
      end else begin
        held = 1;
        p_r = u_if.row_idx; p_c = u_if.col_idx; p_a = u_if.addr; p_l = u_if.idx_last;
      end
      cyc++;
      step();
    end
    n_cmp++;
    if (got != n) begin
      n_err++;
      $display("FAIL %s timeout: got %0d beats, expected %0d", name, got, n);
    end
    u_if.idx_ready = 1'($urandom_range(0, 1));
    n_cmp++;
    if ({u_if.idx_valid, done, busy} !== 3'b011) begin
      n_err++;
      $display("FAIL %s done_pulse: got valid=%b done=%b busy=%b, expected 0 1 1",
               name, u_if.idx_valid, done, busy);
    end
    step();
    n_cmp++;
    if ({u_if.idx_valid, done, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL %s after_done: got valid=%b done=%b busy=%b, expected 0 0 0",
               name, u_if.idx_valid, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.idx_ready = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("reset_release");
  endtask

  task automatic test_row_inner();
    run_job("row_inner_3x2", 3, 2, 64'h1000, 64'h100, 1'b0, 0, 1'b0);
  endtask

  task automatic test_col_inner();
    run_job("col_inner_3x2", 3, 2, 64'h1000, 64'h100, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_job("bp_pattern_2x2", 2, 2, 64'h2000, 64'h40, 1'b0, 2, 1'b0);
    run_job("bp_random_4x3", 4, 3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1, 1'b0);
  endtask

  task automatic test_zero_dims();
    run_job("zero_rows", 0, 5, 64'h3000, 64'h10, 1'b0, 0, 1'b0);
    run_job("zero_cols", 4, 0, 64'h3000, 64'h10, 1'b1, 0, 1'b0);
  endtask

  task automatic test_full_size();
    run_job("full_32x32", 32, 32, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8, 1'b0, 1, 1'b0);
  endtask

  task automatic test_abort();
    int unsigned got = 0, cyc = 0;
    cfg_rows = 4; cfg_cols = 4; cfg_base = 64'h5000; cfg_row_stride = 64'h80;
    cfg_inner_col = 1'b0;
    u_if.idx_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (got < 3 && cyc < 20) begin
      if (u_if.idx_valid === 1'b1) got++;
      cyc++;
      step();
    end
    n_cmp++;
    if (got != 3) begin
      n_err++;
      $display("FAIL abort_setup: got %0d beats, expected 3", got);
    end
    abort = 1'b1;
    u_if.idx_ready = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({u_if.idx_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_idle: got valid=%b busy=%b done=%b, expected 0 0 0",
               u_if.idx_valid, busy, done);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      abort = 1'($urandom_range(0, 1));
      step();
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL abort_no_done: got busy=%b done=%b, expected 0 0", busy, done);
      end
    end
    abort = 1'b0;
    run_job("after_abort", 3, 3, 64'h9000, 64'h20, 1'b1, 0, 1'b0);
    run_job("abort_with_start", 2, 3, 64'hA000, 64'h30, 1'b0, 1, 1'b1);
  endtask

  task automatic test_reset_mid_job();
    cfg_rows = 4; cfg_cols = 4; cfg_base = 64'hB000; cfg_row_stride = 64'h10;
    cfg_inner_col = 1'b1;
    u_if.idx_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_idle_outputs("reset_mid_job");
    rst_n = 1'b1;
    step();
    check_idle_outputs("reset_mid_job_after");
    run_job("after_reset", 2, 2, 64'hC000, 64'h100, 1'b0, 1, 1'b0);
  endtask

  task automatic test_random_jobs();
    for (int unsigned j = 0; j < 8; j++) begin
      run_job("random_job", $urandom_range(0, 7), $urandom_range(0, 7),
              {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_row_inner();
    test_col_inner();
    test_backpressure();
    test_zero_dims();
    test_full_size();
    test_abort();
    test_reset_mid_job();
    test_random_jobs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
